modbus_rx_framer: RTL and testbench

Receive-side framer between the UART byte receiver and the `crc16` block. It delimits Modbus RTU frames by line silence (t3.5) and writes each received byte to the frame RAM. It feeds every byte to `crc16` and clears the CRC between frames. At frame end it checks address, length and CRC residue, then reports the frame to the command logic.

---
 rtl/modbus_rx_framer_pkg.sv | 37 +++
 rtl/modbus_rx_framer_t35_timer.sv | 29 ++
 rtl/modbus_rx_framer.sv | 139 +++++++++++++
 tb/tb_modbus_rx_framer.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/modbus_rx_framer_pkg.sv
// rtl/modbus_rx_framer_pkg.sv - shared state, error codes and frame constants for the Modbus RTU receive framer
package modbus_rx_framer_pkg;

    typedef enum logic [1:0] {
        WAIT_SIL = 2'd0,
        IDLE     = 2'd1,
        RECV     = 2'd2,
        CHECK    = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        ERR_OK       = 2'd0,
        ERR_CRC      = 2'd1,
        ERR_SHORT    = 2'd2,
        ERR_OVERFLOW = 2'd3
    } frame_err_t;

    // Address (1) + function (1) + CRC (2) is the smallest legal RTU frame
    localparam logic [8:0] MIN_FRAME_LEN  = 9'd4;
    localparam logic [7:0] BROADCAST_ADDR = 8'h00;

    // Overflow outranks a short frame, which outranks a bad CRC residue
    function automatic frame_err_t frame_err_code(
        input logic        ovf,
        input logic [8:0]  len,
        input logic [15:0] residue
    );
        if (ovf)
            return ERR_OVERFLOW;
        if (len < MIN_FRAME_LEN)
            return ERR_SHORT;
        if (residue != 16'h0000)
            return ERR_CRC;
        return ERR_OK;
    endfunction

endpackage

// File: rtl/modbus_rx_framer_t35_timer.sv
// rtl/modbus_rx_framer_t35_timer.sv - line-silence timer that flags t3.5 since the last received byte
module t35_timer #(
    parameter int T35_CYCLES = 200000
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    input  logic enable,
    output logic timeout
);

    localparam int W = (T35_CYCLES > 1) ? $clog2(T35_CYCLES) : 1;
    localparam logic [W-1:0] TERM = W'(T35_CYCLES - 1);

    logic [W-1:0] cnt;

    // Count cycles since the last byte, holding at terminal count
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt <= '0;
        else if (restart)
            cnt <= '0;
        else if (enable && !timeout)
            cnt <= cnt + 1'b1;
    end

    assign timeout = (cnt == TERM);

endmodule

// File: rtl/modbus_rx_framer.sv
// rtl/modbus_rx_framer.sv - delimits RTU frames by silence, stores bytes, drives crc16 and reports frame status
module modbus_rx_framer
    import modbus_rx_framer_pkg::*;
#(
    parameter int T35_CYCLES = 200000,
    parameter int MAX_LEN    = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic [7:0]  dev_addr,
    output logic        crc_en,
    output logic        crc_clr,
    output logic [7:0]  crc_data,
    input  logic [15:0] crc_in,
    output logic        ram_we,
    output logic [7:0]  ram_addr,
    output logic [7:0]  ram_wdata,
    output logic        frame_done,
    output logic        frame_ok,
    output logic [1:0]  frame_err,
    output logic [8:0]  frame_len
);

    localparam logic [9:0] MAX_LEN_W = 10'(MAX_LEN);

    state_t     state, state_d;
    logic       timeout;
    logic       skid_vld, skid_take, accept, entering_check, addr_match;
    logic [7:0] skid_data, acc_byte, addr_byte;
    logic [8:0] count;
    logic       ovf;
    frame_err_t err_code;

    t35_timer #(.T35_CYCLES(T35_CYCLES)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .restart (rx_valid),
        .enable  (1'b1),
        .timeout (timeout)
    );

    assign addr_match = (addr_byte == dev_addr) || (addr_byte == BROADCAST_ADDR);
    assign err_code   = frame_err_code(ovf, count, crc_in);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= WAIT_SIL;
        else
            state <= state_d;
    end

    // Next state and byte acceptance; a byte on the terminal-count cycle keeps the frame open
    always_comb begin
        state_d        = state;
        skid_take      = (state == IDLE) && skid_vld;
        accept         = skid_take || (rx_valid && ((state == IDLE) || (state == RECV)));
        acc_byte       = skid_take ? skid_data : rx_data;
        entering_check = 1'b0;
        case (state)
            WAIT_SIL: if (!rx_valid && timeout) state_d = IDLE;
            IDLE:     if (accept) state_d = RECV;
            RECV: begin
                if (!rx_valid && timeout) begin
                    state_d        = CHECK;
                    entering_check = 1'b1;
                end
            end
            CHECK:    state_d = IDLE;
            default:  state_d = WAIT_SIL;
        endcase
    end

    // Datapath: CRC feed, RAM writes, byte count, skid byte and frame report (all registered)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            crc_en     <= 1'b0;
            crc_clr    <= 1'b0;
            crc_data   <= '0;
            ram_we     <= 1'b0;
            ram_addr   <= '0;
            ram_wdata  <= '0;
            frame_done <= 1'b0;
            frame_ok   <= 1'b0;
            frame_err  <= '0;
            frame_len  <= '0;
            count      <= '0;
            addr_byte  <= '0;
            ovf        <= 1'b0;
            skid_vld   <= 1'b0;
            skid_data  <= '0;
        end else begin
            // crc_clr is high only during CHECK, where no byte can be accepted
            crc_en     <= accept;
            crc_clr    <= entering_check;
            ram_we     <= 1'b0;
            frame_done <= 1'b0;
            if (accept)
                crc_data <= acc_byte;

            if ((state == CHECK) && rx_valid) begin
                skid_vld  <= 1'b1;
                skid_data <= rx_data;
            end else if (skid_take) begin
                skid_vld  <= 1'b0;
            end

            if (accept && (state == IDLE)) begin
                count     <= 9'd1;
                addr_byte <= acc_byte;
                ovf       <= 1'b0;
                ram_we    <= 1'b1;
                ram_addr  <= '0;
                ram_wdata <= acc_byte;
            end else if (accept) begin
                if ({1'b0, count} < MAX_LEN_W) begin
                    ram_we    <= 1'b1;
                    ram_addr  <= count[7:0];
                    ram_wdata <= acc_byte;
                end else begin
                    ovf <= 1'b1;
                end
                if (count != 9'h1FF)
                    count <= count + 9'd1;
            end

            // The crc16 residue has been stable for t3.5 when the frame closes
            if (entering_check && addr_match) begin
                frame_done <= 1'b1;
                frame_len  <= count;
                frame_err  <= err_code;
                frame_ok   <= (err_code == ERR_OK);
            end
        end
    end

endmodule

// File: tb/tb_modbus_rx_framer.sv
// tb/tb_modbus_rx_framer.sv - directed self-checking bench for modbus_rx_framer with a crc16 and RAM model
module tb_modbus_rx_framer;

    localparam int T35 = 50;
    typedef logic [7:0] bq_t [$];

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic [7:0]  dev_addr = 8'h01;
    logic        crc_en, crc_clr, ram_we, frame_done, frame_ok;
    logic [7:0]  crc_data, ram_addr, ram_wdata;
    logic [15:0] crc_in;
    logic [1:0]  frame_err;
    logic [8:0]  frame_len;

    always #5 clk = ~clk;

    modbus_rx_framer #(.T35_CYCLES(T35), .MAX_LEN(256)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .dev_addr   (dev_addr),
        .crc_en     (crc_en),
        .crc_clr    (crc_clr),
        .crc_data   (crc_data),
        .crc_in     (crc_in),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .frame_done (frame_done),
        .frame_ok   (frame_ok),
        .frame_err  (frame_err),
        .frame_len  (frame_len)
    );

    int errors = 0;
    int checks = 0;

    function automatic logic [15:0] crc_step(input logic [15:0] c_in, input logic [7:0] d);
        logic [15:0] c;
        c = c_in ^ {8'h00, d};
        for (int k = 0; k < 8; k++)
            c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
        return c;
    endfunction

    function automatic bq_t with_crc(input bq_t d);
        bq_t r;
        logic [15:0] c;
        c = 16'hFFFF;
        r = d;
        foreach (d[i]) c = crc_step(c, d[i]);
        r.push_back(c[7:0]);
        r.push_back(c[15:8]);
        return r;
    endfunction

    // crc16 model: crc_en has priority over crc_clr
    logic [15:0] crc_reg;
    always @(posedge clk or negedge rst) begin
        if (!rst)         crc_reg <= 16'hFFFF;
        else if (crc_en)  crc_reg <= crc_step(crc_reg, crc_data);
        else if (crc_clr) crc_reg <= 16'hFFFF;
    end
    assign crc_in = crc_reg;

    // Frame RAM model and write counter
    logic [7:0] mem [0:255];
    int wr_cnt = 0;
    int cyc = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
            wr_cnt <= wr_cnt + 1;
        end
    end

    // Output monitor sampled on the falling edge
    int done_cnt = 0, crc_en_cnt = 0, both_cnt = 0, rx_cyc = 0, done_cyc = 0;
    logic [8:0] last_len = '0;
    logic [1:0] last_err = '0;
    logic       last_ok = 1'b0;
    always @(negedge clk) begin
        if (rx_valid) rx_cyc <= cyc;
        if (crc_en) crc_en_cnt <= crc_en_cnt + 1;
        if (crc_en && crc_clr) both_cnt <= both_cnt + 1;
        if (frame_done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
            last_len <= frame_len;
            last_err <= frame_err;
            last_ok  <= frame_ok;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        @(posedge clk); #1;
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        repeat (gap) @(posedge clk);
    endtask

    task automatic send_frame(input bq_t fr);
        foreach (fr[i]) send_byte(fr[i], 3);
    endtask

    task automatic settle();
        repeat (T35 + 15) @(posedge clk);
    endtask

    bq_t f_good, f_bad, f_other, f_bcast, f_short;
    int  base, wr_base;

    initial begin
        f_good  = '{8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h0A, 8'hC5, 8'hCD};
        f_bad   = '{8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h0A, 8'hC5, 8'hCC};
        f_other = with_crc('{8'h02, 8'h03, 8'h00, 8'h00, 8'h00, 8'h0A});
        f_bcast = with_crc('{8'h00, 8'h03, 8'h00, 8'h00, 8'h00, 8'h0A});
        f_short = '{8'h01, 8'h03, 8'h00};

        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", {24'h0, crc_en, crc_clr, crc_data, ram_we, ram_addr, ram_wdata,
                              frame_done, frame_ok, frame_err, frame_len}, 64'h0);
        @(posedge clk); #1 rst = 1'b1;

        // Bytes straight after reset fall in WAIT_SIL
        send_frame(f_good);
        settle();
        chk("wait_sil_no_done", done_cnt, 0);
        chk("wait_sil_no_crc_en", crc_en_cnt, 0);

        // Good frame, with first-byte output timing
        @(posedge clk); #1;
        rx_data = 8'h01; rx_valid = 1'b1;
        @(posedge clk); #1 rx_valid = 1'b0;
        @(negedge clk);
        chk("first_byte_outputs", {crc_en, crc_data, ram_we, ram_addr, ram_wdata},
            {1'b1, 8'h01, 1'b1, 8'h00, 8'h01});
        repeat (3) @(posedge clk);
        for (int i = 1; i < 8; i++) send_byte(f_good[i], 3);
        settle();
        chk("good_done", done_cnt, 1);
        chk("good_status", {last_ok, last_err, last_len}, {1'b1, 2'd0, 9'd8});
        chk("good_latency", done_cyc - rx_cyc, T35 + 1);
        chk("good_ram", {mem[0], mem[1], mem[2], mem[3], mem[4], mem[5], mem[6], mem[7]},
            64'h0103_0000_000A_C5CD);

        send_frame(f_bad);
        settle();
        chk("bad_crc_done", done_cnt, 2);
        chk("bad_crc_status", {last_ok, last_err, last_len}, {1'b0, 2'd1, 9'd8});

        send_frame(f_good);
        settle();
        chk("after_bad_status", {done_cnt[7:0], last_ok, last_err, last_len}, {8'd3, 1'b1, 2'd0, 9'd8});

        send_frame(f_other);
        settle();
        chk("other_addr_dropped", done_cnt, 3);

        send_frame(f_bcast);
        settle();
        chk("bcast_status", {done_cnt[7:0], last_ok, last_err, last_len}, {8'd4, 1'b1, 2'd0, 9'd8});

        send_frame(f_short);
        settle();
        chk("short_status", {done_cnt[7:0], last_ok, last_err, last_len}, {8'd5, 1'b0, 2'd2, 9'd3});

        // Last byte lands exactly on terminal count: frame continues
        for (int i = 0; i < 6; i++) send_byte(f_good[i], 3);
        send_byte(f_good[6], T35 - 2);
        send_byte(f_good[7], 3);
        settle();
        chk("tc_extend_status", {done_cnt[7:0], last_ok, last_err, last_len}, {8'd6, 1'b1, 2'd0, 9'd8});

        // One cycle later the frame closes; the late byte goes through the skid into a dropped frame
        for (int i = 0; i < 6; i++) send_byte(f_good[i], 3);
        send_byte(f_good[6], T35 - 1);
        send_byte(f_good[7], 3);
        settle();
        chk("split_status", {done_cnt[7:0], last_ok, last_err, last_len}, {8'd7, 1'b0, 2'd1, 9'd7});
        chk("skid_byte_ram0", mem[0], 8'hCD);

        send_frame(f_good);
        settle();
        chk("after_skid_status", {done_cnt[7:0], last_ok, last_err, last_len}, {8'd8, 1'b1, 2'd0, 9'd8});

        // 300 back-to-back bytes
        wr_base = wr_cnt;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            rx_data  = (i == 0) ? 8'h01 : 8'(i);
            rx_valid = 1'b1;
        end
        @(posedge clk); #1 rx_valid = 1'b0;
        settle();
        chk("ovf_status", {done_cnt[7:0], last_ok, last_err, last_len}, {8'd9, 1'b0, 2'd3, 9'd300});
        chk("ovf_write_count", wr_cnt - wr_base, 256);
        chk("ovf_ram_ends", {mem[0], mem[255]}, {8'h01, 8'hFF});

        // Reset in the middle of a frame
        base = done_cnt;
        for (int i = 0; i < 3; i++) send_byte(f_good[i], 3);
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        settle();
        settle();
        chk("midframe_reset_no_done", done_cnt - base, 0);
        send_frame(f_good);
        settle();
        chk("post_reset_status", {done_cnt[7:0] - base[7:0], last_ok, last_err, last_len},
            {8'd1, 1'b1, 2'd0, 9'd8});

        chk("crc_en_clr_exclusive", both_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
